// File: rtl/shift_pkg.sv
// Shared encodings for the serial shift unit: operation modes and the controller states.
package shift_pkg;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit-position shift/rotate step; returns the shifted word and the bit pushed out.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             right_shift,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    logic fill;

    always_comb begin
        fill      = 1'b0;
        next_data = data;
        out_bit   = 1'b0;
        if (right_shift) begin
            out_bit = data[0];
            case (mode)
                MODE_ARITH:  fill = data[WIDTH-1];
                MODE_ROTATE: fill = data[0];
                default:     fill = 1'b0;
            endcase
            next_data = {fill, data[WIDTH-1:1]};
        end else begin
            out_bit   = data[WIDTH-1];
            // Arithmetic left is the same as logical left.
            fill      = (mode == MODE_ROTATE) ? data[WIDTH-1] : 1'b0;
            next_data = {data[WIDTH-2:0], fill};
        end
    end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter: moves one bit position per clock, with start/busy/done handshake.
module serial_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               right_shift,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done,
    output logic               carry_out,
    output logic               zero
);

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               right_q;
    logic [1:0]         mode_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data       (data_q),
        .right_shift(right_q),
        .mode       (mode_q),
        .next_data  (step_data),
        .out_bit    (step_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            mode_q  <= MODE_LOGICAL;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        data_q  <= data_in;
                        right_q <= right_shift;
                        mode_q  <= mode;
                        cnt_q   <= shamt;
                        carry_q <= 1'b0;
                        if (shamt != '0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here; latched controls stay fixed.
                    data_q  <= step_data;
                    carry_q <= step_bit;
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign carry_out = carry_q;
    assign zero      = (data_q == '0);

endmodule

// File: tb/tb_serial_shift_unit.sv
// Bench for serial_shift_unit: arithmetic reference model checked every cycle plus directed ops.
module tb_serial_shift_unit;

    localparam int W = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       right_shift;
    logic [1:0] mode;
    logic [3:0] data_in;
    logic [2:0] shamt;
    logic [3:0] data_out;
    logic       busy;
    logic       done;
    logic       carry_out;
    logic       zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    serial_shift_unit #(
        .WIDTH  (4),
        .SHAMT_W(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .right_shift(right_shift),
        .mode       (mode),
        .data_in    (data_in),
        .shamt      (shamt),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .carry_out  (carry_out),
        .zero       (zero)
    );

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result {carry, data} from plain shift arithmetic.
    function automatic logic [4:0] model_op(input logic [3:0] d, input int n,
                                            input logic right, input logic [1:0] md);
        logic [7:0] t;
        logic [3:0] r;
        logic       c;
        int         k;
        if (n == 0) return {1'b0, d};
        if (md == 2'b10) begin
            k = n % W;
            if (right) begin
                t = {d, d} >> k;
                r = t[3:0];
                c = r[3];
            end else begin
                t = {d, d} << k;
                r = t[7:4];
                c = r[0];
            end
        end else if (right && md == 2'b01) begin
            r = 4'($signed(d) >>> n);
            c = d[(n - 1 < W) ? n - 1 : W - 1];
        end else if (right) begin
            r = d >> n;
            c = (n <= W) ? d[n-1] : 1'b0;
        end else begin
            r = d << n;
            c = (n <= W) ? d[W-n] : 1'b0;
        end
        return {c, r};
    endfunction

    // Reference model: tracks cycle timing and the final result only.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_data = 4'd0;
    logic       m_carry = 1'b0;
    logic [4:0] m_pend = 5'd0;
    int         m_left = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_data  = 4'd0;
            m_carry = 1'b0;
            m_left  = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_data  = m_pend[3:0];
                m_carry = m_pend[4];
            end
        end else if (start) begin
            m_pend = model_op(data_in, int'(shamt), right_shift, mode);
            if (shamt == 3'd0) begin
                m_done  = 1'b1;
                m_data  = m_pend[3:0];
                m_carry = m_pend[4];
            end else begin
                m_busy = 1'b1;
                m_done = 1'b0;
                m_left = int'(shamt);
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            if (!m_busy) begin
                check("data_out", int'(data_out), int'(m_data));
                check("carry_out", int'(carry_out), int'(m_carry));
                check("zero", int'(zero), int'(m_data == 4'd0));
            end
        end
    end

    // Called just after a negedge; start is seen at the next rising edge (edge 0).
    task automatic do_op(input logic [3:0] d, input logic [2:0] n, input logic right,
                         input logic [1:0] md, input logic [3:0] exp_d, input logic exp_c,
                         input int exp_cyc);
        int cyc;
        start       = 1'b1;
        data_in     = d;
        shamt       = n;
        right_shift = right;
        mode        = md;
        @(negedge clock);
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~n;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clock);
            cyc = cyc + 1;
        end
        check("latency", cyc, exp_cyc);
        check("result", int'(data_out), int'(exp_d));
        check("carry", int'(carry_out), int'(exp_c));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        right_shift = 1'b0;
        mode        = 2'b00;
        data_in     = 4'd0;
        shamt       = 3'd0;
        repeat (2) @(negedge clock);
        check("rst_data", int'(data_out), 0);
        check("rst_zero", int'(zero), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_carry", int'(carry_out), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        do_op(4'b1011, 3'd2, 1'b1, 2'b00, 4'b0010, 1'b1, 3);
        check("t1_zero", int'(zero), 0);
        @(negedge clock);
        do_op(4'b1000, 3'd3, 1'b1, 2'b01, 4'b1111, 1'b0, 4);
        @(negedge clock);
        do_op(4'b1001, 3'd5, 1'b0, 2'b10, 4'b0011, 1'b1, 6);
        @(negedge clock);
        do_op(4'b0110, 3'd7, 1'b0, 2'b00, 4'b0000, 1'b0, 8);
        check("t4_zero", int'(zero), 1);
        @(negedge clock);
        do_op(4'b0110, 3'd7, 1'b0, 2'b11, 4'b0000, 1'b0, 8);
        @(negedge clock);
        do_op(4'b1101, 3'd6, 1'b1, 2'b10, 4'b0111, 1'b0, 7);
        @(negedge clock);
        do_op(4'b1010, 3'd6, 1'b1, 2'b01, 4'b1111, 1'b1, 7);
        @(negedge clock);

        // shamt = 0, then a second start issued in the DONE cycle.
        do_op(4'b0101, 3'd0, 1'b1, 2'b00, 4'b0101, 1'b0, 1);
        check("t5_busy", int'(busy), 0);
        do_op(4'b0011, 3'd1, 1'b0, 2'b00, 4'b0110, 1'b0, 2);
        repeat (4) @(negedge clock);
        check("hold", int'(data_out), 6);

        // Ignored start during SHIFT, then an aborting reset.
        start       = 1'b1;
        data_in     = 4'b1100;
        shamt       = 3'd5;
        right_shift = 1'b1;
        mode        = 2'b00;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start   = 1'b1;
        data_in = 4'b1111;
        shamt   = 3'd1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_data", int'(data_out), 0);
        check("abort_zero", int'(zero), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("no_done", int'(done), 0);
        end
        do_op(4'b0111, 3'd1, 1'b1, 2'b01, 4'b0011, 1'b1, 2);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
